// File: rtl/sr_pkg.sv
// Shared constants and parity helper for the secure_router family.
// The router generates parity with sr_parity and the collector checks it.
package sr_pkg;

    localparam int unsigned SR_DATA_W = 6;
    localparam int unsigned SR_LANES  = 4;
    localparam int unsigned SR_LANE_W = 2;
    localparam int unsigned SR_WORD_W = 7;

    function automatic logic sr_parity(input logic [SR_DATA_W-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/sr_rr_arbiter.sv
// 4-way round-robin arbiter: grants the first requester at or after rr_ptr.
// Purely combinational; the caller owns the pointer register.
module sr_rr_arbiter
    import sr_pkg::*;
(
    input  logic [SR_LANES-1:0]  req,
    input  logic                 en,
    input  logic [SR_LANE_W-1:0] rr_ptr,
    output logic                 gnt_valid,
    output logic [SR_LANE_W-1:0] gnt_idx
);

    logic [SR_LANE_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int k = SR_LANES - 1; k >= 0; k--) begin
            idx = rr_ptr + SR_LANE_W'(k);
            if (req[idx]) begin
                gnt_valid = en;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/secure_router_collector.sv
// Merges four parity-protected lanes into one tagged stream via a small FIFO.
// Define SR_COLLECTOR_ERRCNT_EN to add saturating per-lane parity-error counters.
module secure_router_collector
    import sr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SR_WORD_W-1:0]           in_data0,
    input  logic [SR_WORD_W-1:0]           in_data1,
    input  logic [SR_WORD_W-1:0]           in_data2,
    input  logic [SR_WORD_W-1:0]           in_data3,
    input  logic [SR_LANES-1:0]            in_valid,
    output logic [SR_LANES-1:0]            in_ready,
    output logic [SR_LANE_W+SR_DATA_W-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           par_err,
    output logic [SR_LANE_W-1:0]           err_lane
`ifdef SR_COLLECTOR_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]               err_cnt0,
    output logic [CNT_W-1:0]               err_cnt1,
    output logic [CNT_W-1:0]               err_cnt2,
    output logic [CNT_W-1:0]               err_cnt3
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned OutW = SR_LANE_W + SR_DATA_W;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("secure_router_collector: FIFO_DEPTH must be a power of 2 >= 2, CNT_W >= 1");
    end

    logic [SR_WORD_W-1:0] in_word [SR_LANES];
    logic [SR_WORD_W-1:0] hold_q  [SR_LANES];
    logic [SR_WORD_W-1:0] hold_d  [SR_LANES];
    logic [SR_LANES-1:0]  hold_v_q, hold_v_d;
    logic [SR_LANE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                 par_err_q, par_err_d;
    logic [SR_LANE_W-1:0] err_lane_q, err_lane_d;

    logic [OutW-1:0]      mem_q [FIFO_DEPTH];
    logic [OutW-1:0]      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 full, empty, push, pop;
    logic                 gnt_valid, gnt_good;
    logic [SR_LANE_W-1:0] gnt_idx;
    logic [SR_WORD_W-1:0] gnt_word;

    assign in_word[0] = in_data0;
    assign in_word[1] = in_data1;
    assign in_word[2] = in_data2;
    assign in_word[3] = in_data3;

    assign full      = (cnt_q == CntW'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign in_ready  = ~hold_v_q;
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign par_err   = par_err_q;
    assign err_lane  = err_lane_q;

    sr_rr_arbiter u_arb (
        .req       (hold_v_q),
        .en        (~full),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_word = hold_q[gnt_idx];
    assign gnt_good = (sr_parity(gnt_word[SR_DATA_W-1:0]) == gnt_word[SR_WORD_W-1]);
    assign push     = gnt_valid & gnt_good;
    assign pop      = out_valid & out_ready;

    always_comb begin
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        rr_ptr_d   = rr_ptr_q;
        par_err_d  = 1'b0;
        err_lane_d = err_lane_q;
        if (gnt_valid) begin
            hold_v_d[gnt_idx] = 1'b0;
            rr_ptr_d          = gnt_idx + SR_LANE_W'(1);
            if (!gnt_good) begin
                par_err_d  = 1'b1;
                err_lane_d = gnt_idx;
            end
        end
        // A lane granted this cycle still has hold_v_q set, so it cannot refill until next edge.
        for (int i = 0; i < SR_LANES; i++) begin
            if (in_valid[i] && !hold_v_q[i]) begin
                hold_d[i]   = in_word[i];
                hold_v_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {gnt_idx, gnt_word[SR_DATA_W-1:0]};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SR_LANES; i++) hold_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            hold_v_q   <= '0;
            rr_ptr_q   <= '0;
            par_err_q  <= 1'b0;
            err_lane_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            mem_q      <= mem_d;
            hold_v_q   <= hold_v_d;
            rr_ptr_q   <= rr_ptr_d;
            par_err_q  <= par_err_d;
            err_lane_q <= err_lane_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef SR_COLLECTOR_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q [SR_LANES];
    logic [CNT_W-1:0] err_cnt_d [SR_LANES];

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (gnt_valid && !gnt_good && err_cnt_q[gnt_idx] != '1) begin
            err_cnt_d[gnt_idx] = err_cnt_q[gnt_idx] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SR_LANES; i++) err_cnt_q[i] <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt0 = err_cnt_q[0];
    assign err_cnt1 = err_cnt_q[1];
    assign err_cnt2 = err_cnt_q[2];
    assign err_cnt3 = err_cnt_q[3];
`endif

endmodule
